enc_ctrl: RTL and testbench

- Sequencing controller in front of the ECC encoder pipeline (stage 1 + stage 2; 3 modes: 4/11/26 info bits → 8/16/32-bit codewords).
- Accepts info words with a per-beat mode over a valid/ready handshake and launches them into the encoder.
- Tracks in-flight beats and buffers returned codewords in an output FIFO.
- Guarantees enc_mod never changes while any beat is inside the encoder.

---
 rtl/enc_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_enc_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_ctrl.sv
// Sequencing controller for the ECC encoder: launches info words, tracks in-flight beats, buffers codewords.
// Optional build macro ENC_CTRL_PAD_CHK_EN adds a sticky pad_err flag for non-zero bits above the mode's codeword width.
module enc_ctrl #(
    parameter int unsigned MAX_CODEWORD_WIDTH = 32,
    parameter int unsigned MAX_INFO_WIDTH     = 26,
    parameter int unsigned ENC_LATENCY        = 2,
    parameter int unsigned OUT_FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_INFO_WIDTH-1:0]     in_data,
    input  logic [1:0]                    in_mod,
    output logic [MAX_INFO_WIDTH-1:0]     enc_data_in,
    output logic [1:0]                    enc_mod,
    input  logic [MAX_CODEWORD_WIDTH-1:0] enc_data_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] out_data,
    output logic [1:0]                    out_mod,
    output logic                          busy,
    output logic                          mod_err,
`ifdef ENC_CTRL_PAD_CHK_EN
    output logic                          pad_err,
`endif
    input  logic                          clr_err
);

    localparam int unsigned AW = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(OUT_FIFO_DEPTH + ENC_LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [MAX_INFO_WIDTH-1:0]       r_enc_data;
    logic [1:0]                      r_enc_mod;
    logic [ENC_LATENCY-1:0]          r_dl_vld;
    logic [1:0]                      r_dl_mod [ENC_LATENCY];
    logic [CW-1:0]                   r_infl_cnt;
    logic [CW-1:0]                   r_fifo_cnt;
    logic [AW-1:0]                   r_wr_ptr;
    logic [AW-1:0]                   r_rd_ptr;
    logic [MAX_CODEWORD_WIDTH-1:0]   r_mem     [OUT_FIFO_DEPTH];
    logic [1:0]                      r_mem_mod [OUT_FIFO_DEPTH];
    logic                            r_mod_err;

    logic                            w_legal;
    logic                            w_mod_diff;
    logic                            w_credit_ok;
    logic                            w_acc;
    logic                            w_launch;
    logic                            w_illegal;
    logic                            w_push;
    logic                            w_pop;
    logic [CW-1:0]                   w_infl_nxt;
    logic [MAX_INFO_WIDTH-1:0]       w_info_mask;

    assign w_legal     = (in_mod != 2'b11);
    assign w_mod_diff  = w_legal && (in_mod != r_enc_mod);
    assign w_credit_ok = (r_infl_cnt + r_fifo_cnt) < CW'(OUT_FIFO_DEPTH);
    assign in_ready    = rst && (r_state != S_DRAIN) && w_credit_ok
                         && !((r_state == S_RUN) && w_mod_diff);
    assign w_acc       = in_valid && in_ready;
    assign w_launch    = w_acc && w_legal;
    assign w_illegal   = w_acc && !w_legal;
    assign w_push      = r_dl_vld[ENC_LATENCY-1];
    assign w_pop       = (r_fifo_cnt != '0) && out_ready;
    assign w_infl_nxt  = r_infl_cnt + CW'(w_launch) - CW'(w_push);

    // Info bits above the mode's info width are forced to zero before launch.
    always_comb begin
        w_info_mask = '0;
        case (in_mod)
            2'b00:   w_info_mask = MAX_INFO_WIDTH'(32'h0000_000F);
            2'b01:   w_info_mask = MAX_INFO_WIDTH'(32'h0000_07FF);
            2'b10:   w_info_mask = MAX_INFO_WIDTH'(32'h03FF_FFFF);
            default: w_info_mask = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // DRAIN holds off a mode change until every launched beat has returned.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_infl_nxt == '0)            w_state_nxt = S_IDLE;
                else if (in_valid && w_mod_diff) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: if (w_infl_nxt == '0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_enc_data <= '0;
            r_enc_mod  <= 2'b00;
            r_dl_vld   <= '0;
            for (int unsigned i = 0; i < ENC_LATENCY; i++) r_dl_mod[i] <= 2'b00;
            r_infl_cnt <= '0;
        end else begin
            if (w_launch) begin
                r_enc_data <= in_data & w_info_mask;
                r_enc_mod  <= in_mod;
            end
            for (int unsigned i = ENC_LATENCY - 1; i > 0; i--) begin
                r_dl_vld[i] <= r_dl_vld[i-1];
                r_dl_mod[i] <= r_dl_mod[i-1];
            end
            r_dl_vld[0] <= w_launch;
            r_dl_mod[0] <= in_mod;
            r_infl_cnt  <= w_infl_nxt;
        end
    end

    // Output FIFO; the credit check in in_ready keeps pushes from overflowing it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            for (int unsigned i = 0; i < OUT_FIFO_DEPTH; i++) begin
                r_mem[i]     <= '0;
                r_mem_mod[i] <= 2'b00;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr]     <= enc_data_out;
                r_mem_mod[r_wr_ptr] <= r_dl_mod[ENC_LATENCY-1];
                r_wr_ptr            <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r_mod_err <= 1'b0;
        else if (w_illegal) r_mod_err <= 1'b1;
        else if (clr_err)   r_mod_err <= 1'b0;
    end

`ifdef ENC_CTRL_PAD_CHK_EN
    logic [MAX_CODEWORD_WIDTH-1:0] w_cw_mask;
    logic                          r_pad_err;

    always_comb begin
        w_cw_mask = '1;
        case (r_dl_mod[ENC_LATENCY-1])
            2'b00:   w_cw_mask = MAX_CODEWORD_WIDTH'(32'h0000_00FF);
            2'b01:   w_cw_mask = MAX_CODEWORD_WIDTH'(32'h0000_FFFF);
            default: w_cw_mask = '1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                        r_pad_err <= 1'b0;
        else if (w_push && |(enc_data_out & ~w_cw_mask)) r_pad_err <= 1'b1;
        else if (clr_err)                                r_pad_err <= 1'b0;
    end

    assign pad_err = r_pad_err;
`endif

    assign enc_data_in = r_enc_data;
    assign enc_mod     = r_enc_mod;
    assign out_valid   = (r_fifo_cnt != '0);
    assign out_data    = r_mem[r_rd_ptr];
    assign out_mod     = r_mem_mod[r_rd_ptr];
    assign busy        = (r_state != S_IDLE) || (r_fifo_cnt != '0);
    assign mod_err     = r_mod_err;

endmodule

// File: tb/tb_enc_ctrl.sv
// Bench for enc_ctrl: stub encoder pipeline, queue-based reference model, directed and random stimulus.
module tb_enc_ctrl;

    localparam int unsigned CWW = 32;
    localparam int unsigned IW  = 26;
    localparam int LAT = 2;
    localparam int DEP = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [IW-1:0]   in_data = '0;
    logic [1:0]      in_mod = 2'b00;
    logic [IW-1:0]   enc_data_in;
    logic [1:0]      enc_mod;
    logic [CWW-1:0]  enc_data_out;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [CWW-1:0]  out_data;
    logic [1:0]      out_mod;
    logic            busy;
    logic            mod_err;
    logic            clr_err = 1'b0;
`ifdef ENC_CTRL_PAD_CHK_EN
    logic            pad_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    enc_ctrl #(
        .MAX_CODEWORD_WIDTH(CWW), .MAX_INFO_WIDTH(IW),
        .ENC_LATENCY(LAT), .OUT_FIFO_DEPTH(DEP)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mod(in_mod),
        .enc_data_in(enc_data_in), .enc_mod(enc_mod), .enc_data_out(enc_data_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mod(out_mod),
        .busy(busy), .mod_err(mod_err),
`ifdef ENC_CTRL_PAD_CHK_EN
        .pad_err(pad_err),
`endif
        .clr_err(clr_err)
    );

    function automatic logic [31:0] cw_mask(input logic [1:0] m);
        case (m)
            2'b00:   return 32'h0000_00FF;
            2'b01:   return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [25:0] info_mask(input logic [1:0] m);
        case (m)
            2'b00:   return 26'h000_000F;
            2'b01:   return 26'h000_07FF;
            default: return 26'h3FF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] stub(input logic [25:0] x, input logic [1:0] m);
        logic [31:0] v;
        v = {6'd0, x};
        return (v ^ (v << 5) ^ 32'hA5A5_A5A5) & cw_mask(m);
    endfunction

    // Stub encoder: one register stage plus the controller's own launch register = 2 edges.
    logic [31:0] enc_pipe;
    always @(posedge clk) enc_pipe <= stub(enc_data_in, enc_mod);
    assign enc_data_out = enc_pipe;

    typedef struct { int due; logic [25:0] info; logic [1:0] mod; } fl_t;
    typedef struct { logic [31:0] cw; logic [1:0] mod; } fe_t;

    fl_t        m_infl[$];
    fe_t        m_fifo[$];
    bit         m_drain = 1'b0;
    logic [1:0] m_mode = 2'b00;
    logic [25:0] m_launch = '0;
    bit         m_err = 1'b0;
    int         edge_no = 0;
    bit         m_acc, m_pop, m_set_drain;
    fl_t        m_new;
    fe_t        m_out;

    function automatic bit model_ready();
        bit legal;
        legal = (in_mod != 2'b11);
        return rst && !m_drain && ((m_infl.size() + m_fifo.size()) < DEP)
               && !(m_infl.size() > 0 && legal && in_mod != m_mode);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_infl.delete();
            m_fifo.delete();
            m_drain  = 1'b0;
            m_mode   = 2'b00;
            m_launch = '0;
            m_err    = 1'b0;
        end else begin
            m_acc = in_valid && model_ready();
            m_pop = (m_fifo.size() > 0) && out_ready;
            m_set_drain = !m_drain && (m_infl.size() > 0) && in_valid
                          && (in_mod != 2'b11) && (in_mod != m_mode);
            edge_no++;
            if (m_pop) void'(m_fifo.pop_front());
            if (m_infl.size() > 0 && m_infl[0].due == edge_no) begin
                m_out.cw  = stub(m_infl[0].info, m_infl[0].mod);
                m_out.mod = m_infl[0].mod;
                m_fifo.push_back(m_out);
                void'(m_infl.pop_front());
            end
            if (m_acc && in_mod != 2'b11) begin
                m_new.due  = edge_no + LAT;
                m_new.info = in_data & info_mask(in_mod);
                m_new.mod  = in_mod;
                m_infl.push_back(m_new);
                m_mode   = in_mod;
                m_launch = m_new.info;
            end
            if (m_acc && in_mod == 2'b11) m_err = 1'b1;
            else if (clr_err)             m_err = 1'b0;
            if (m_set_drain) m_drain = 1'b1;
            if (m_infl.size() == 0) m_drain = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(model_ready()));
        chk("out_valid", 32'(out_valid), 32'(m_fifo.size() > 0));
        if (m_fifo.size() > 0) begin
            chk("out_data", out_data, m_fifo[0].cw);
            chk("out_mod", 32'(out_mod), 32'(m_fifo[0].mod));
        end else if (!rst) begin
            chk("rst_out_data", out_data, 32'h0);
            chk("rst_out_mod", 32'(out_mod), 32'h0);
        end
        chk("busy", 32'(busy), 32'(m_infl.size() > 0 || m_drain || m_fifo.size() > 0));
        chk("mod_err", 32'(mod_err), 32'(m_err));
        chk("enc_mod", 32'(enc_mod), 32'(m_mode));
        chk("enc_data_in", 32'(enc_data_in), 32'(m_launch));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        in_valid = 1'b0;
        clr_err  = 1'b0;
        out_ready = 1'b1;
        repeat (n) tick();
    endtask

    int n;
    logic [1:0] rmod;

    initial begin
        repeat (3) tick();
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'h0);
        chk("reset_mod_err", 32'(mod_err), 32'h0);
        rst = 1'b1;
        tick();

        // Single beat with upper info bits masked off.
        in_valid = 1'b1; in_mod = 2'b00; in_data = 26'h3FF_FFFF;
        tick();
        in_valid = 1'b0;
        chk("single_enc_data_in", 32'(enc_data_in), 32'h0000_000F);
        chk("single_enc_mod", 32'(enc_mod), 32'h0);
        chk("single_no_early", 32'(out_valid), 32'h0);
        tick();
        chk("single_no_early2", 32'(out_valid), 32'h0);
        tick();
        chk("single_out_valid", 32'(out_valid), 32'h1);
        chk("single_out_data", out_data, 32'h0000_004A);
        chk("single_out_mod", 32'(out_mod), 32'h0);
        settle(4);

        // Back-to-back mode 01.
        in_valid = 1'b1; in_mod = 2'b01; n = 0;
        for (int i = 0; i < 8; i++) begin
            in_data = 26'($urandom);
            #1;
            if (in_ready) n++;
            tick();
        end
        chk("b2b_ready_cycles", 32'(n), 32'd8);
        settle(6);

        // Mode change forces a drain.
        in_valid = 1'b1; in_mod = 2'b00;
        repeat (3) begin in_data = 26'($urandom); tick(); end
        in_mod = 2'b10; in_data = 26'($urandom); n = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (in_ready) break;
            n++;
            tick();
        end
        chk("drain_stall_cycles", 32'(n), 32'd2);
        tick();
        in_valid = 1'b0;
        chk("drain_new_mode", 32'(enc_mod), 32'h2);
        settle(6);

        // Backpressure: credits run out at FIFO depth.
        out_ready = 1'b0; in_valid = 1'b1; in_mod = 2'b01; n = 0;
        for (int i = 0; i < 10; i++) begin
            in_data = 26'($urandom);
            #1;
            if (in_ready) n++;
            tick();
        end
        chk("bp_accepts", 32'(n), 32'd4);
        chk("bp_in_ready", 32'(in_ready), 32'h0);
        in_valid = 1'b0; out_ready = 1'b1; n = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (out_valid) n++;
            tick();
        end
        chk("bp_pops", 32'(n), 32'd4);
        in_valid = 1'b1; #1;
        chk("bp_resume", 32'(in_ready), 32'h1);
        settle(6);

        // Illegal mode handling.
        in_valid = 1'b1; in_mod = 2'b11; in_data = 26'($urandom);
        #1;
        chk("illegal_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        chk("illegal_err_set", 32'(mod_err), 32'h1);
        repeat (2) tick();
        chk("illegal_no_write", 32'(out_valid), 32'h0);
        chk("illegal_not_busy", 32'(busy), 32'h0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("illegal_err_clr", 32'(mod_err), 32'h0);
        in_valid = 1'b1; in_mod = 2'b11; clr_err = 1'b1; tick();
        in_valid = 1'b0; clr_err = 1'b0;
        chk("illegal_set_wins", 32'(mod_err), 32'h1);
        clr_err = 1'b1; tick();
        settle(4);

        // Reset with beats both in flight and in the FIFO.
        out_ready = 1'b0; in_valid = 1'b1; in_mod = 2'b00;
        repeat (4) begin in_data = 26'($urandom); tick(); end
        in_valid = 1'b0;
        chk("rstmid_pre_valid", 32'(out_valid), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_out_valid", 32'(out_valid), 32'h0);
        chk("rstmid_busy", 32'(busy), 32'h0);
        repeat (2) tick();
        rst = 1'b1; out_ready = 1'b1; n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) n++;
        end
        chk("rstmid_no_stale", 32'(n), 32'd0);

        // Randomized traffic.
        rmod = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0)
                rmod = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            in_valid  = ($urandom_range(0, 3) != 0);
            in_mod    = rmod;
            in_data   = 26'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_err   = ($urandom_range(0, 31) == 0);
            if (c == 1500) begin
                rst = 1'b0;
                repeat (2) tick();
                rst = 1'b1;
            end
            tick();
        end
        settle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
